// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle between the ID/EXE/MEM/WB stages and the hazard/forwarding unit.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned MC_CW  = 4,
  parameter int unsigned CNT_W  = 16
);
  // ID stage
  logic              id_valid;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              two_src;
  logic              id_mc_start;
  logic              flush;
  // Downstream destinations
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_en;
  // Controls back to the pipeline
  logic              hazard;
  logic              mc_busy;
  logic              freeze;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic [MC_CW-1:0]  mc_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, src1, src2, two_src, id_mc_start, flush,
    output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, wb_dest, wb_en,
    input  hazard, mc_busy, freeze, fwd_sel_a, fwd_sel_b, mc_count, stall_count
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_mc_start, flush,
    input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, wb_dest, wb_en,
    output hazard, mc_busy, freeze, fwd_sel_a, fwd_sel_b, mc_count, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection, EXE operand forwarding and multi-cycle freeze control for the 5-stage pipeline.
module hazard_forward_unit #(
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned MC_CYCLES = 8,
  parameter int unsigned MC_CW     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_forward_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mc_state_e         state_q, state_d;
  logic [MC_CW-1:0]  mc_count_q, mc_count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              ex_valid_q, ex_valid_d;
  logic              ex_two_q, ex_two_d;
  logic [REG_AW-1:0] ex_src1_q, ex_src1_d;
  logic [REG_AW-1:0] ex_src2_q, ex_src2_d;

  logic              hit_exe_c, hit_mem_c, hazard_c;
  logic              mc_req_c, mc_busy_c, freeze_c;
  logic [1:0]        fwd_a_c, fwd_b_c;

  // RAW detection of the ID sources against the EXE and MEM destinations
  always_comb begin
    hit_exe_c = bus.exe_wb_en &&
                ((bus.src1 == bus.exe_dest) || (bus.two_src && (bus.src2 == bus.exe_dest)));
    hit_mem_c = bus.mem_wb_en &&
                ((bus.src1 == bus.mem_dest) || (bus.two_src && (bus.src2 == bus.mem_dest)));
    if (FWD_EN != 0) begin
      // With forwarding only a load still in EXE cannot supply its result in time
      hazard_c = bus.id_valid && bus.exe_mem_r_en && hit_exe_c;
    end else begin
      hazard_c = bus.id_valid && (hit_exe_c || hit_mem_c);
    end
  end

  // Multi-cycle next state; a pending data hazard delays the start, reset blocks it
  always_comb begin
    state_d    = state_q;
    mc_count_d = mc_count_q;
    mc_busy_c  = 1'b0;
    mc_req_c   = rst && bus.id_valid && bus.id_mc_start && !hazard_c && !bus.flush;
    case (state_q)
      IDLE: begin
        mc_busy_c = mc_req_c;
        if (mc_req_c) begin
          if (MC_CYCLES == 1) begin
            state_d = DONE;
          end else begin
            state_d    = BUSY;
            mc_count_d = MC_LOAD;
          end
        end
      end
      BUSY: begin
        mc_busy_c = 1'b1;
        if (bus.flush) begin
          state_d    = IDLE;
          mc_count_d = '0;
        end else if (mc_count_q == MC_CW'(1)) begin
          state_d    = DONE;
          mc_count_d = '0;
        end else begin
          mc_count_d = mc_count_q - MC_CW'(1);
        end
      end
      DONE: begin
        // One unfrozen cycle lets the op leave ID before a new start is considered
        state_d    = IDLE;
        mc_count_d = '0;
      end
      default: begin
        state_d    = IDLE;
        mc_count_d = '0;
      end
    endcase
  end

  assign freeze_c = hazard_c | mc_busy_c;

  // ID/EXE source shadow and saturating freeze counter
  always_comb begin
    ex_valid_d = 1'b0;
    ex_src1_d  = ex_src1_q;
    ex_src2_d  = ex_src2_q;
    ex_two_d   = ex_two_q;
    if (!(freeze_c || bus.flush)) begin
      ex_valid_d = bus.id_valid;
      ex_src1_d  = bus.src1;
      ex_src2_d  = bus.src2;
      ex_two_d   = bus.two_src;
    end
    stall_d = stall_q;
    if (freeze_c && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // EXE operand selects; the younger MEM result wins over WB
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if ((FWD_EN != 0) && ex_valid_q) begin
      if (bus.mem_wb_en && (bus.mem_dest == ex_src1_q)) begin
        fwd_a_c = 2'b01;
      end else if (bus.wb_en && (bus.wb_dest == ex_src1_q)) begin
        fwd_a_c = 2'b10;
      end
      if (ex_two_q) begin
        if (bus.mem_wb_en && (bus.mem_dest == ex_src2_q)) begin
          fwd_b_c = 2'b01;
        end else if (bus.wb_en && (bus.wb_dest == ex_src2_q)) begin
          fwd_b_c = 2'b10;
        end
      end
    end
  end

  // Multi-cycle state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mc_count_q <= '0;
    end else begin
      state_q    <= state_d;
      mc_count_q <= mc_count_d;
    end
  end

  // Shadow and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_src1_q  <= '0;
      ex_src2_q  <= '0;
      ex_two_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_src1_q  <= ex_src1_d;
      ex_src2_q  <= ex_src2_d;
      ex_two_q   <= ex_two_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.hazard      = hazard_c;
  assign bus.mc_busy     = mc_busy_c;
  assign bus.freeze      = freeze_c;
  assign bus.fwd_sel_a   = fwd_a_c;
  assign bus.fwd_sel_b   = fwd_b_c;
  assign bus.mc_count    = mc_count_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three configurations driven in lockstep, checked against a model.
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       id_valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two_src;
    logic       id_mc_start;
    logic       flush;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic [3:0] wb_dest;
    logic       wb_en;
  } stim_t;

  typedef struct {
    bit       id_valid;
    int       src1;
    int       src2;
    bit       two_src;
    int       exe_dest;
    bit       exe_wb_en;
    bit       exe_mem_r_en;
    int       mem_dest;
    bit       mem_wb_en;
    bit       exp_haz_fwd;
    bit       exp_haz_nofwd;
  } vec_t;

  // u0: forwarding, 8-cycle op; u1: no forwarding, 4-bit counter; u2: forwarding, 1-cycle op
  localparam int FWD_C [3] = '{1, 0, 1};
  localparam int MCC_C [3] = '{8, 8, 1};
  localparam int CMAX_C[3] = '{65535, 15, 65535};

  logic  clk;
  logic  rst_n;
  stim_t s;

  hazard_forward_unit_if #(.REG_AW(4), .MC_CW(4), .CNT_W(16)) if0 ();
  hazard_forward_unit_if #(.REG_AW(4), .MC_CW(4), .CNT_W(4))  if1 ();
  hazard_forward_unit_if #(.REG_AW(4), .MC_CW(4), .CNT_W(16)) if2 ();

  hazard_forward_unit #(.REG_AW(4), .FWD_EN(1), .MC_CYCLES(8), .MC_CW(4), .CNT_W(16))
    u0 (.clk(clk), .rst(rst_n), .bus(if0.slave));
  hazard_forward_unit #(.REG_AW(4), .FWD_EN(0), .MC_CYCLES(8), .MC_CW(4), .CNT_W(4))
    u1 (.clk(clk), .rst(rst_n), .bus(if1.slave));
  hazard_forward_unit #(.REG_AW(4), .FWD_EN(1), .MC_CYCLES(1), .MC_CW(4), .CNT_W(16))
    u2 (.clk(clk), .rst(rst_n), .bus(if2.slave));

  assign {if0.id_valid, if0.src1, if0.src2, if0.two_src, if0.id_mc_start, if0.flush, if0.exe_dest,
          if0.exe_wb_en, if0.exe_mem_r_en, if0.mem_dest, if0.mem_wb_en, if0.wb_dest, if0.wb_en} = s;
  assign {if1.id_valid, if1.src1, if1.src2, if1.two_src, if1.id_mc_start, if1.flush, if1.exe_dest,
          if1.exe_wb_en, if1.exe_mem_r_en, if1.mem_dest, if1.mem_wb_en, if1.wb_dest, if1.wb_en} = s;
  assign {if2.id_valid, if2.src1, if2.src2, if2.two_src, if2.id_mc_start, if2.flush, if2.exe_dest,
          if2.exe_wb_en, if2.exe_mem_r_en, if2.mem_dest, if2.mem_wb_en, if2.wb_dest, if2.wb_en} = s;

  logic        haz_o [3];
  logic        busy_o[3];
  logic        frz_o [3];
  logic [1:0]  fa_o  [3];
  logic [1:0]  fb_o  [3];
  logic [3:0]  cnt_o [3];
  logic [15:0] st_o  [3];

  assign {haz_o[0], busy_o[0], frz_o[0], fa_o[0], fb_o[0], cnt_o[0]} =
         {if0.hazard, if0.mc_busy, if0.freeze, if0.fwd_sel_a, if0.fwd_sel_b, if0.mc_count};
  assign {haz_o[1], busy_o[1], frz_o[1], fa_o[1], fb_o[1], cnt_o[1]} =
         {if1.hazard, if1.mc_busy, if1.freeze, if1.fwd_sel_a, if1.fwd_sel_b, if1.mc_count};
  assign {haz_o[2], busy_o[2], frz_o[2], fa_o[2], fb_o[2], cnt_o[2]} =
         {if2.hazard, if2.mc_busy, if2.freeze, if2.fwd_sel_a, if2.fwd_sel_b, if2.mc_count};
  assign st_o[0] = if0.stall_count;
  assign st_o[1] = 16'(if1.stall_count);
  assign st_o[2] = if2.stall_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pipeline-level view (who owes how many freeze cycles, what sits in EXE)
  bit m_exv [3];
  int m_s1  [3];
  int m_s2  [3];
  bit m_two [3];
  int m_owed[3];   // remaining counted freeze cycles of the running op
  bit m_cool[3];   // op just finished and is leaving ID this cycle
  int m_stall[3];
  bit e_haz [3];
  bit e_busy[3];
  bit e_frz [3];
  bit e_req [3];
  int e_fa  [3];
  int e_fb  [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_exv[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_two[k] = 0;
      m_owed[k] = 0; m_cool[k] = 0; m_stall[k] = 0;
    end
  endtask

  function automatic int fwd_of(int k, int src);
    if (FWD_C[k] == 0 || !m_exv[k]) return 0;
    if (s.mem_wb_en && int'(s.mem_dest) == src) return 1;
    if (s.wb_en && int'(s.wb_dest) == src) return 2;
    return 0;
  endfunction

  task automatic model_eval();
    bit hit_e, hit_m;
    hit_e = s.exe_wb_en && (s.src1 == s.exe_dest || (s.two_src && s.src2 == s.exe_dest));
    hit_m = s.mem_wb_en && (s.src1 == s.mem_dest || (s.two_src && s.src2 == s.mem_dest));
    for (int k = 0; k < 3; k++) begin
      e_haz[k]  = s.id_valid && ((FWD_C[k] != 0) ? (s.exe_mem_r_en && hit_e) : (hit_e || hit_m));
      e_req[k]  = rst_n && s.id_valid && s.id_mc_start && !e_haz[k] && !s.flush;
      e_busy[k] = (m_owed[k] > 0) || (!m_cool[k] && e_req[k]);
      e_frz[k]  = e_haz[k] || e_busy[k];
      e_fa[k]   = fwd_of(k, m_s1[k]);
      e_fb[k]   = m_two[k] ? fwd_of(k, m_s2[k]) : 0;
    end
  endtask

  task automatic model_clock();
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      if (e_frz[k] || s.flush) begin
        m_exv[k] = 0;
      end else begin
        m_exv[k] = s.id_valid; m_s1[k] = int'(s.src1); m_s2[k] = int'(s.src2); m_two[k] = s.two_src;
      end
      if (e_frz[k] && m_stall[k] < CMAX_C[k]) m_stall[k] = m_stall[k] + 1;
      if (s.flush) begin
        m_owed[k] = 0; m_cool[k] = 0;
      end else if (m_owed[k] > 0) begin
        m_cool[k] = (m_owed[k] == 1);
        m_owed[k] = m_owed[k] - 1;
      end else if (m_cool[k]) begin
        m_cool[k] = 0;
      end else if (e_req[k]) begin
        m_owed[k] = MCC_C[k] - 1;
        m_cool[k] = (MCC_C[k] == 1);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: compare every DUT against the model, then advance model and clock together
  task automatic cycle(input string tag);
    #2;
    model_eval();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.hazard", tag, k),  32'(haz_o[k]),  int'(e_haz[k]));
      chk($sformatf("%s.u%0d.mc_busy", tag, k), 32'(busy_o[k]), int'(e_busy[k]));
      chk($sformatf("%s.u%0d.freeze", tag, k),  32'(frz_o[k]),  int'(e_frz[k]));
      chk($sformatf("%s.u%0d.fwd_a", tag, k),   32'(fa_o[k]),   e_fa[k]);
      chk($sformatf("%s.u%0d.fwd_b", tag, k),   32'(fb_o[k]),   e_fb[k]);
      chk($sformatf("%s.u%0d.mc_count", tag, k), 32'(cnt_o[k]), m_owed[k]);
      chk($sformatf("%s.u%0d.stall", tag, k),   32'(st_o[k]),   m_stall[k]);
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  vec_t vt[8];
  int   base0;

  initial begin
    // Hazard table: valid, src1, src2, two, exe_dest, exe_wb, exe_ld, mem_dest, mem_wb, exp fwd, exp no-fwd
    vt[0] = '{1, 0, 7, 0,  7, 1, 0,  0, 0, 0, 0};
    vt[1] = '{1, 0, 7, 1,  7, 1, 0,  0, 0, 0, 1};
    vt[2] = '{0, 0, 7, 1,  7, 1, 1,  0, 0, 0, 0};
    vt[3] = '{1, 0, 7, 1,  7, 1, 1,  0, 0, 1, 1};
    vt[4] = '{1, 5, 2, 0,  9, 1, 1,  5, 1, 0, 1};
    vt[5] = '{1, 5, 2, 0,  5, 0, 1,  5, 0, 0, 0};
    vt[6] = '{1, 15, 15, 1, 15, 1, 1, 15, 1, 1, 1};
    vt[7] = '{1, 4, 6, 1,  6, 1, 1,  0, 0, 1, 1};

    // Reset state, hazard still follows inputs while counters stay cleared
    rst_n = 1'b0;
    s = '0;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.u%0d.hazard", k), 32'(haz_o[k]), 0);
      chk($sformatf("rst.u%0d.freeze", k), 32'(frz_o[k]), 0);
      chk($sformatf("rst.u%0d.fwd_a", k), 32'(fa_o[k]), 0);
      chk($sformatf("rst.u%0d.mc_count", k), 32'(cnt_o[k]), 0);
      chk($sformatf("rst.u%0d.stall", k), 32'(st_o[k]), 0);
    end
    s.id_valid = 1; s.src1 = 4'd2; s.exe_dest = 4'd2; s.exe_wb_en = 1; s.exe_mem_r_en = 1;
    #1;
    chk("rst.hazard_live", 32'(haz_o[0]), 1);
    @(posedge clk); #1;
    chk("rst.stall_held", 32'(st_o[0]), 0);
    s = '0;
    #1 rst_n = 1'b1;

    // Table-driven hazard vectors
    for (int i = 0; i < 8; i++) begin
      s = '0;
      s.id_valid = vt[i].id_valid; s.src1 = 4'(vt[i].src1); s.src2 = 4'(vt[i].src2);
      s.two_src = vt[i].two_src; s.exe_dest = 4'(vt[i].exe_dest); s.exe_wb_en = vt[i].exe_wb_en;
      s.exe_mem_r_en = vt[i].exe_mem_r_en; s.mem_dest = 4'(vt[i].mem_dest); s.mem_wb_en = vt[i].mem_wb_en;
      #1;
      chk($sformatf("vec%0d.fwd", i),   32'(haz_o[0]), int'(vt[i].exp_haz_fwd));
      chk($sformatf("vec%0d.nofwd", i), 32'(haz_o[1]), int'(vt[i].exp_haz_nofwd));
      chk($sformatf("vec%0d.fwd1", i),  32'(haz_o[2]), int'(vt[i].exp_haz_fwd));
      cycle($sformatf("vec%0d", i));
    end

    // Load-use: one stall, then the consumer in EXE takes the WB value
    s = '0; cycle("lu.idle");
    s.id_valid = 1; s.src1 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1; s.exe_mem_r_en = 1;
    #1 chk("lu.stall", 32'(haz_o[0]), 1);
    cycle("lu0");
    s.exe_wb_en = 0; s.exe_mem_r_en = 0; s.mem_dest = 4'd3; s.mem_wb_en = 1;
    #1 chk("lu.released", 32'(haz_o[0]), 0);
    cycle("lu1");
    s.src1 = 4'd9; s.mem_wb_en = 0; s.mem_dest = 4'd0; s.wb_dest = 4'd3; s.wb_en = 1;
    #1 chk("lu.fwd_wb", 32'(fa_o[0]), 2);
    cycle("lu2");

    // Forwarding priority: MEM over WB, then WB alone, never without forwarding
    s = '0; s.id_valid = 1; s.src1 = 4'd5;
    cycle("fp0");
    s.mem_dest = 4'd5; s.mem_wb_en = 1; s.wb_dest = 4'd5; s.wb_en = 1;
    #1;
    chk("fp.mem_first", 32'(fa_o[0]), 1);
    chk("fp.nofwd", 32'(fa_o[1]), 0);
    cycle("fp1");
    s.mem_wb_en = 0;
    #1;
    chk("fp.wb_only", 32'(fa_o[0]), 2);
    chk("fp.nofwd2", 32'(fa_o[1]), 0);
    cycle("fp2");

    // Multi-cycle op: exactly eight frozen cycles, then one released cycle without restart
    s = '0; cycle("mc.idle");
    base0 = m_stall[0];
    s.id_valid = 1; s.id_mc_start = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("mc.frz%0d", i), 32'(frz_o[0]), 1);
      cycle($sformatf("mc%0d", i));
    end
    #1;
    chk("mc.done_frz", 32'(frz_o[0]), 0);
    chk("mc.done_busy", 32'(busy_o[0]), 0);
    cycle("mc.done");
    s.id_mc_start = 0;
    #1 chk("mc.stall8", 32'(st_o[0]), base0 + 8);
    cycle("mc.after");

    // Flush in the third BUSY cycle aborts the op
    s = '0; s.id_valid = 1; s.id_mc_start = 1;
    cycle("fl.start"); cycle("fl.b1"); cycle("fl.b2");
    s.flush = 1;
    #1 chk("fl.busy_in_flush", 32'(busy_o[0]), 1);
    cycle("fl.b3");
    s = '0;
    #1;
    chk("fl.freeze", 32'(frz_o[0]), 0);
    chk("fl.mc_count", 32'(cnt_o[0]), 0);
    cycle("fl.after");

    // Twenty hazard cycles saturate the 4-bit counter
    s = '0; s.id_valid = 1; s.src1 = 4'd1; s.exe_dest = 4'd1; s.exe_wb_en = 1; s.exe_mem_r_en = 1;
    for (int i = 0; i < 20; i++) cycle("sat");
    s = '0;
    #1 chk("sat.hold15", 32'(st_o[1]), 15);
    cycle("sat.after");

    // Asynchronous reset in the third frozen cycle of an op
    s = '0; s.id_valid = 1; s.id_mc_start = 1;
    cycle("ar.start"); cycle("ar.b1");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.freeze", 32'(frz_o[0]), 0);
    chk("ar.mc_count", 32'(cnt_o[0]), 0);
    chk("ar.stall", 32'(st_o[0]), 0);
    chk("ar.fwd_a", 32'(fa_o[0]), 0);
    chk("ar.fwd_b", 32'(fb_o[0]), 0);
    model_reset();
    s = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("ar.after");

    // Randomized traffic with small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      s.id_valid     = ($urandom_range(0, 3) != 0);
      s.src1         = 4'($urandom_range(0, 3));
      s.src2         = 4'($urandom_range(0, 3));
      s.two_src      = ($urandom_range(0, 1) != 0);
      s.id_mc_start  = ($urandom_range(0, 5) == 0);
      s.flush        = ($urandom_range(0, 7) == 0);
      s.exe_dest     = 4'($urandom_range(0, 3));
      s.exe_wb_en    = ($urandom_range(0, 1) != 0);
      s.exe_mem_r_en = ($urandom_range(0, 2) == 0);
      s.mem_dest     = 4'($urandom_range(0, 3));
      s.mem_wb_en    = ($urandom_range(0, 1) != 0);
      s.wb_dest      = 4'($urandom_range(0, 3));
      s.wb_en        = ($urandom_range(0, 1) != 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
